// File: rtl/lab_pkg.sv
// Shared types and helpers for the shape job scheduler: FSM states, the queued
// job record and the on-screen coordinate limits.
package lab_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_RELEASE,
    S_GAP
  } state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] diameter;
    logic [2:0] colour;
    logic       clear;
  } job_t;

  // Clamp the centre onto the screen and force an even diameter.
  function automatic job_t sanitise(input logic [7:0] x, input logic [6:0] y,
                                    input logic [7:0] diameter,
                                    input logic [2:0] colour, input logic clear);
    job_t j;
    j.x        = (x > 8'(SCREEN_W - 1)) ? 8'(SCREEN_W - 1) : x;
    j.y        = (y > 7'(SCREEN_H - 1)) ? 7'(SCREEN_H - 1) : y;
    j.diameter = {diameter[7:1], 1'b0};
    j.colour   = colour;
    j.clear    = clear;
    return j;
  endfunction

endpackage

// File: rtl/shape_job_scheduler_if.sv
// Command push handshake, engine launch handshakes and status of the shape job
// scheduler. The slave modport is the scheduler's view; master is its environment.
interface shape_job_scheduler_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_centre_x;
  logic [6:0]  cmd_centre_y;
  logic [7:0]  cmd_diameter;
  logic [2:0]  cmd_colour;
  logic        cmd_clear;

  logic        tri_start;
  logic        tri_done;
  logic [7:0]  tri_centre_x;
  logic [6:0]  tri_centre_y;
  logic [7:0]  tri_diameter;
  logic [2:0]  tri_colour;

  logic        clr_start;
  logic        clr_done;

  logic        busy;
  logic [15:0] jobs_done;

  modport slave (
    input  cmd_valid, cmd_centre_x, cmd_centre_y, cmd_diameter, cmd_colour, cmd_clear,
    input  tri_done, clr_done,
    output cmd_ready, tri_start, tri_centre_x, tri_centre_y, tri_diameter, tri_colour,
    output clr_start, busy, jobs_done
  );

  modport master (
    output cmd_valid, cmd_centre_x, cmd_centre_y, cmd_diameter, cmd_colour, cmd_clear,
    output tri_done, clr_done,
    input  cmd_ready, tri_start, tri_centre_x, tri_centre_y, tri_diameter, tri_colour,
    input  clr_start, busy, jobs_done
  );

endinterface

// File: rtl/job_fifo.sv
// Power-of-two circular FIFO of job records with first-word fall-through read.
// Push while full and pop while empty are ignored.
module job_fifo
  import lab_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  job_t                   push_data,
  input  logic                   pop,
  output job_t                   pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int unsigned CW         = AW + 1;
  localparam logic [AW:0] FULL_COUNT = CW'(DEPTH);

  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; only the pointers and count define
  // validity, which keeps the array a plain RAM without per-bit reset logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shape_job_scheduler.sv
// Queues sanitised shape commands and runs them one at a time on either the
// triangle engine or the clear-screen engine, with a minimum idle gap between jobs.
module shape_job_scheduler
  import lab_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  shape_job_scheduler_if.slave bus
);

  localparam int         CW       = $clog2(DEPTH) + 1;
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t          state, state_d;
  logic [3:0]      gap_cnt, gap_cnt_d;
  job_t            cur, cur_d;
  logic            tri_start_q, tri_start_d;
  logic            clr_start_q, clr_start_d;
  logic [15:0]     jobs_done_q, jobs_done_d;

  job_t            push_job;
  job_t            head;
  logic            push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            sel_done;

  assign push_job      = sanitise(bus.cmd_centre_x, bus.cmd_centre_y, bus.cmd_diameter,
                                  bus.cmd_colour, bus.cmd_clear);
  assign bus.cmd_ready = rst_n & ~fifo_full;
  assign push          = bus.cmd_valid & bus.cmd_ready;
  // The head stays queued while its job runs, so the FIFO count covers the
  // active job; it is dequeued only once the engine has finished.
  assign fifo_pop      = (state == S_RELEASE);
  assign sel_done      = cur.clear ? bus.clr_done : bus.tri_done;

  job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_job),
    .pop      (fifo_pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    gap_cnt_d   = gap_cnt;
    cur_d       = cur;
    tri_start_d = tri_start_q;
    clr_start_d = clr_start_q;
    jobs_done_d = jobs_done_q;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          cur_d   = head;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tri_start_d = ~cur.clear;
        clr_start_d = cur.clear;
        state_d     = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (sel_done) begin
          tri_start_d = 1'b0;
          clr_start_d = 1'b0;
          state_d     = S_RELEASE;
        end
      end
      S_RELEASE: begin
        jobs_done_d = jobs_done_q + 16'd1;
        gap_cnt_d   = '0;
        state_d     = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = S_IDLE;
        else                     gap_cnt_d = gap_cnt + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      gap_cnt     <= '0;
      cur         <= '0;
      tri_start_q <= 1'b0;
      clr_start_q <= 1'b0;
      jobs_done_q <= '0;
    end else begin
      state       <= state_d;
      gap_cnt     <= gap_cnt_d;
      cur         <= cur_d;
      tri_start_q <= tri_start_d;
      clr_start_q <= clr_start_d;
      jobs_done_q <= jobs_done_d;
    end
  end

  assign bus.tri_start    = tri_start_q;
  assign bus.clr_start    = clr_start_q;
  assign bus.tri_centre_x = cur.x;
  assign bus.tri_centre_y = cur.y;
  assign bus.tri_diameter = cur.diameter;
  assign bus.tri_colour   = cur.colour;
  assign bus.jobs_done    = jobs_done_q;
  assign bus.busy         = (fifo_count != '0) || (state != S_IDLE);

endmodule

// File: tb/tb_shape_job_scheduler.sv
// Directed and randomised-stream bench for shape_job_scheduler with a
// behavioural triangle/clear engine driven from the test tasks.
module tb_shape_job_scheduler;
  import lab_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  shape_job_scheduler_if bus ();

  shape_job_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid    = 1'b0;
    bus.cmd_centre_x = '0;
    bus.cmd_centre_y = '0;
    bus.cmd_diameter = '0;
    bus.cmd_colour   = '0;
    bus.cmd_clear    = 1'b0;
    bus.tri_done     = 1'b0;
    bus.clr_done     = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_cmd(input logic [7:0] x, input logic [6:0] y, input logic [7:0] d,
                          input logic [2:0] c, input logic clr, output logic ok);
    bus.cmd_centre_x = x;
    bus.cmd_centre_y = y;
    bus.cmd_diameter = d;
    bus.cmd_colour   = c;
    bus.cmd_clear    = clr;
    bus.cmd_valid    = 1'b1;
    ok = bus.cmd_ready;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output logic seen);
    int n = 0;
    while (!(bus.tri_start || bus.clr_start) && n < 200) begin
      tick();
      n++;
    end
    seen = bus.tri_start || bus.clr_start;
  endtask

  task automatic finish_job(input logic clr);
    if (clr) bus.clr_done = 1'b1;
    else     bus.tri_done = 1'b1;
    tick();
    bus.tri_done = 1'b0;
    bus.clr_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [25:0] args();
    return {bus.tri_centre_x, bus.tri_centre_y, bus.tri_diameter, bus.tri_colour};
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({bus.tri_start, bus.clr_start} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_starts: got %b expected 00", {bus.tri_start, bus.clr_start});
    end
    vectors++;
    if (args() !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_args: got %h expected 0", args());
    end
    vectors++;
    if (bus.jobs_done !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_jobs_done: got %0d expected 0", bus.jobs_done);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    vectors++;
    if (bus.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cmd_ready: got %b expected 0", bus.cmd_ready);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL post_reset_ready_busy: got %b expected 10", {bus.cmd_ready, bus.busy});
    end
  endtask

  task automatic test_single_job();
    logic ok, seen, bad;
    apply_reset();
    // Done inputs while idle must be ignored.
    bus.tri_done = 1'b1;
    bus.clr_done = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({bus.jobs_done, bus.tri_start, bus.clr_start} !== 18'd0) begin
      miscompares++;
      $display("FAIL idle_done_ignored: got jobs %0d starts %b%b expected 0 00",
               bus.jobs_done, bus.tri_start, bus.clr_start);
    end
    bus.tri_done = 1'b0;
    bus.clr_done = 1'b0;
    push_cmd(8'd80, 7'd60, 8'd80, 3'd5, 1'b0, ok);
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL single_push_ready: got %b expected 1", ok);
    end
    tick();
    vectors++;
    if (bus.tri_start !== 1'b0) begin
      miscompares++;
      $display("FAIL single_launch_too_early: got tri_start %b expected 0", bus.tri_start);
    end
    wait_start(seen);
    vectors++;
    if ({seen, bus.tri_start, bus.clr_start} !== 3'b110) begin
      miscompares++;
      $display("FAIL single_start: got seen/tri/clr %b expected 110",
               {seen, bus.tri_start, bus.clr_start});
    end
    vectors++;
    if (args() !== {8'd80, 7'd60, 8'd80, 3'd5}) begin
      miscompares++;
      $display("FAIL single_args: got %h expected %h", args(), {8'd80, 7'd60, 8'd80, 3'd5});
    end
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.clr_done = (i == 50);
      tick();
      if (bus.tri_start !== 1'b1 || bus.clr_start !== 1'b0 ||
          args() !== {8'd80, 7'd60, 8'd80, 3'd5}) bad = 1'b1;
    end
    bus.clr_done = 1'b0;
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL single_hold_stable: got unstable start/args expected stable");
    end
    finish_job(1'b0);
    vectors++;
    if (bus.tri_start !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drop: got tri_start %b expected 0", bus.tri_start);
    end
    tick();
    vectors++;
    if (bus.jobs_done !== 16'd1) begin
      miscompares++;
      $display("FAIL single_jobs_done: got %0d expected 1", bus.jobs_done);
    end
    wait_idle();
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: got busy %b expected 0", bus.busy);
    end
  endtask

  task automatic test_fifo_full();
    logic [25:0] stim [5] = '{{8'd10, 7'd1, 8'd2, 3'd1}, {8'd20, 7'd2, 8'd4, 3'd2},
                              {8'd30, 7'd3, 8'd6, 3'd3}, {8'd40, 7'd4, 8'd8, 3'd4},
                              {8'd50, 7'd5, 8'd10, 3'd5}};
    logic ok, seen;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      push_cmd(stim[i][25:18], stim[i][17:11], stim[i][10:3], stim[i][2:0], 1'b0, ok);
      vectors++;
      if (ok !== (i < 4)) begin
        miscompares++;
        $display("FAIL full_accept_%0d: got ready %b expected %b", i, ok, i < 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      wait_start(seen);
      vectors++;
      if ({seen, bus.tri_start, bus.clr_start} !== 3'b110 || args() !== stim[i]) begin
        miscompares++;
        $display("FAIL full_drain_%0d: got start %b args %h expected 110 %h",
                 i, {seen, bus.tri_start, bus.clr_start}, args(), stim[i]);
      end
      finish_job(1'b0);
    end
    wait_idle();
    vectors++;
    if ({bus.busy, bus.jobs_done} !== {1'b0, 16'd4}) begin
      miscompares++;
      $display("FAIL full_jobs_done: got busy %b jobs %0d expected 0 4", bus.busy, bus.jobs_done);
    end
  endtask

  task automatic test_clear_then_tri();
    logic ok, seen, bad;
    int low;
    apply_reset();
    push_cmd(8'd1, 7'd2, 8'd3, 3'd4, 1'b1, ok);
    push_cmd(8'd0, 7'd119, 8'd30, 3'd3, 1'b0, ok);
    wait_start(seen);
    vectors++;
    if ({seen, bus.tri_start, bus.clr_start} !== 3'b101) begin
      miscompares++;
      $display("FAIL clear_start: got seen/tri/clr %b expected 101",
               {seen, bus.tri_start, bus.clr_start});
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.tri_done = (i == 1);
      tick();
      if ({bus.tri_start, bus.clr_start} !== 2'b01) bad = 1'b1;
    end
    bus.tri_done = 1'b0;
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_ignores_tri_done: got early release expected clr_start held");
    end
    finish_job(1'b1);
    low = 0;
    while (!(bus.tri_start || bus.clr_start) && low < 50) begin
      low++;
      tick();
    end
    vectors++;
    if (low < GAP + 1 || low >= 50) begin
      miscompares++;
      $display("FAIL clear_gap: got %0d low cycles expected >= %0d", low, GAP + 1);
    end
    vectors++;
    if ({bus.tri_start, bus.clr_start} !== 2'b10 || args() !== {8'd0, 7'd119, 8'd30, 3'd3}) begin
      miscompares++;
      $display("FAIL clear_second_job: got start %b args %h expected 10 %h",
               {bus.tri_start, bus.clr_start}, args(), {8'd0, 7'd119, 8'd30, 3'd3});
    end
    finish_job(1'b0);
    wait_idle();
    vectors++;
    if (bus.jobs_done !== 16'd2) begin
      miscompares++;
      $display("FAIL clear_jobs_done: got %0d expected 2", bus.jobs_done);
    end
  endtask

  task automatic test_sanitise();
    logic [25:0] stim [3] = '{{8'd200, 7'd127, 8'd81, 3'd7}, {8'd159, 7'd119, 8'd0, 3'd2},
                              {8'd160, 7'd120, 8'd255, 3'd0}};
    logic [25:0] expv [3] = '{{8'd159, 7'd119, 8'd80, 3'd7}, {8'd159, 7'd119, 8'd0, 3'd2},
                              {8'd159, 7'd119, 8'd254, 3'd0}};
    logic ok, seen;
    apply_reset();
    for (int i = 0; i < 3; i++)
      push_cmd(stim[i][25:18], stim[i][17:11], stim[i][10:3], stim[i][2:0], 1'b0, ok);
    for (int i = 0; i < 3; i++) begin
      wait_start(seen);
      vectors++;
      if (seen !== 1'b1 || args() !== expv[i]) begin
        miscompares++;
        $display("FAIL sanitise_%0d: got args %h expected %h", i, args(), expv[i]);
      end
      finish_job(1'b0);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_job();
    logic ok, seen, bad;
    apply_reset();
    for (int i = 1; i <= 4; i++)
      push_cmd(8'(i * 10), 7'(i), 8'(i * 4), 3'(i), 1'b0, ok);
    wait_start(seen);
    repeat (3) tick();
    vectors++;
    if ({seen, bus.tri_start, bus.busy} !== 3'b111) begin
      miscompares++;
      $display("FAIL midreset_running: got seen/tri/busy %b expected 111",
               {seen, bus.tri_start, bus.busy});
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.tri_start, bus.clr_start, bus.busy, bus.cmd_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_async: got tri/clr/busy/ready %b expected 0000",
               {bus.tri_start, bus.clr_start, bus.busy, bus.cmd_ready});
    end
    vectors++;
    if ({args(), bus.jobs_done} !== 42'd0) begin
      miscompares++;
      $display("FAIL midreset_clear_regs: got args %h jobs %0d expected 0 0",
               args(), bus.jobs_done);
    end
    #2;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.tri_start !== 1'b0 || bus.clr_start !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_no_relaunch: got activity after reset expected none");
    end
    push_cmd(8'd33, 7'd44, 8'd55, 3'd6, 1'b0, ok);
    wait_start(seen);
    vectors++;
    if (seen !== 1'b1 || args() !== {8'd33, 7'd44, 8'd54, 3'd6}) begin
      miscompares++;
      $display("FAIL midreset_new_job: got args %h expected %h", args(),
               {8'd33, 7'd44, 8'd54, 3'd6});
    end
    finish_job(1'b0);
    wait_idle();
    vectors++;
    if (bus.jobs_done !== 16'd1) begin
      miscompares++;
      $display("FAIL midreset_jobs_done: got %0d expected 1", bus.jobs_done);
    end
  endtask

  task automatic test_random_stream();
    job_t        exp_q [$];
    job_t        e;
    int          pushed = 0, started = 0, cycles = 0, low = 100;
    int          arg_bad = 0, overlap = 0, gap_bad = 0;
    int unsigned lat = 0, lat_cnt = 0;
    logic        prev = 1'b0, cur_clr = 1'b0, any;
    logic [7:0]  rx, rd;
    logic [6:0]  ry;
    logic [2:0]  rc;
    logic        rclr;
    apply_reset();
    while ((started < 200 || bus.busy) && cycles < 40000) begin
      any = bus.tri_start || bus.clr_start;
      if (bus.tri_start && bus.clr_start) overlap++;
      if (any && !prev) begin
        started++;
        if (low < GAP + 1) gap_bad++;
        if (exp_q.size() == 0) begin
          arg_bad++;
          $display("FAIL random_unexpected_start: job %0d with empty scoreboard", started);
        end else begin
          e = exp_q.pop_front();
          if (bus.clr_start !== e.clear || (!e.clear && args() !== {e.x, e.y, e.diameter, e.colour})) begin
            arg_bad++;
            $display("FAIL random_job_%0d: got clr %b args %h expected clr %b args %h", started,
                     bus.clr_start, args(), e.clear, {e.x, e.y, e.diameter, e.colour});
          end
        end
        lat     = $urandom_range(0, 50);
        lat_cnt = 0;
        cur_clr = bus.clr_start;
        low     = 0;
      end else if (!any) begin
        low++;
      end
      prev = any;
      if (any) begin
        if (cur_clr) begin
          bus.clr_done = (lat_cnt >= lat);
          bus.tri_done = 1'($urandom_range(0, 1));
        end else begin
          bus.tri_done = (lat_cnt >= lat);
          bus.clr_done = 1'($urandom_range(0, 1));
        end
        lat_cnt++;
      end else begin
        bus.tri_done = 1'($urandom_range(0, 1));
        bus.clr_done = 1'($urandom_range(0, 1));
      end
      bus.cmd_valid = 1'b0;
      if (pushed < 200 && $urandom_range(0, 3) != 0) begin
        rx   = 8'($urandom_range(0, 255));
        ry   = 7'($urandom_range(0, 127));
        rd   = 8'($urandom_range(0, 255));
        rc   = 3'($urandom_range(0, 7));
        rclr = ($urandom_range(0, 7) == 0);
        bus.cmd_centre_x = rx;
        bus.cmd_centre_y = ry;
        bus.cmd_diameter = rd;
        bus.cmd_colour   = rc;
        bus.cmd_clear    = rclr;
        bus.cmd_valid    = 1'b1;
        if (bus.cmd_ready) begin
          e.x        = (rx > 8'd159) ? 8'd159 : rx;
          e.y        = (ry > 7'd119) ? 7'd119 : ry;
          e.diameter = rd & 8'hFE;
          e.colour   = rc;
          e.clear    = rclr;
          exp_q.push_back(e);
          pushed++;
        end
      end
      tick();
      cycles++;
    end
    idle_inputs();
    vectors++;
    if (cycles >= 40000 || started !== 200 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL random_completion: got cycles %0d starts %0d left %0d expected <40000 200 0",
               cycles, started, exp_q.size());
    end
    vectors++;
    if (arg_bad !== 0) begin
      miscompares++;
      $display("FAIL random_scoreboard: got %0d bad jobs expected 0", arg_bad);
    end
    vectors++;
    if (overlap !== 0 || gap_bad !== 0) begin
      miscompares++;
      $display("FAIL random_overlap_gap: got overlap %0d gap violations %0d expected 0 0",
               overlap, gap_bad);
    end
    vectors++;
    if (bus.jobs_done !== 16'd200) begin
      miscompares++;
      $display("FAIL random_jobs_done: got %0d expected 200", bus.jobs_done);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_fifo_full();
    test_clear_then_tri();
    test_sanitise();
    test_reset_mid_job();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shape_job_scheduler.md
SHAPE_JOB_SCHEDULER -- requirements
Module: shape_job_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth in entries (power of 2, 2..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, minimum start-low cycles between engine jobs (1..15).
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-004 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have cmd_valid in 1 and cmd_ready out 1, the valid/ready command push handshake.
REQ-006 SHALL have cmd_centre_x in 8, cmd_centre_y in 7, cmd_diameter in 8, cmd_colour in 3, cmd_clear in 1 (1 = clear-screen job; geometry ignored).
REQ-007 SHALL have tri_start out 1 and tri_done in 1, the triangle-engine handshake.
REQ-008 SHALL have tri_centre_x out 8, tri_centre_y out 7, tri_diameter out 8 and tri_colour out 3 as engine arguments.
REQ-009 SHALL have clr_start out 1 and clr_done in 1, the clear-screen engine handshake.
REQ-010 SHALL have busy out 1 (FIFO non-empty or job active) and jobs_done out 16 (completed-job counter).

Function
REQ-011 SHALL accept a command on a clk edge with cmd_valid && cmd_ready; cmd_ready = FIFO not full.
REQ-012 SHALL sanitise on push: centre_x saturates to 159 if >159; centre_y saturates to 119 if >119; diameter bit0 forced 0.
REQ-013 SHALL execute jobs strictly in FIFO order, one at a time.
REQ-014 SHALL implement FSM IDLE -> LAUNCH -> WAIT_DONE -> RELEASE -> GAP -> IDLE.
REQ-015 IDLE: FIFO non-empty -> pop head into argument registers, go LAUNCH next cycle.
REQ-016 LAUNCH: assert tri_start (or clr_start if cmd_clear) with stable arguments; go WAIT_DONE.
REQ-017 WAIT_DONE: hold start high and arguments stable until selected done sampled 1; then RELEASE.
REQ-018 RELEASE: drop start the cycle after done is sampled; increment jobs_done (wraps 65535 -> 0); go GAP.
REQ-019 GAP: hold both starts low for exactly GAP_CYCLES cycles, then IDLE; earliest next start = GAP_CYCLES+1 cycles after drop.
REQ-020 SHALL never assert tri_start and clr_start together.
REQ-021 SHALL ignore done inputs outside WAIT_DONE and ignore the unselected engine's done.
REQ-022 Simultaneous push and pop with FIFO full SHALL be allowed only after the pop frees space; cmd_ready is combinational on current count (no bypass).
REQ-023 Push to empty FIFO while IDLE: job launches no earlier than 2 cycles after the push edge.
REQ-024 diameter 0 SHALL be issued normally (engine defines result); scheduler adds no special case.
REQ-025 All outputs SHALL be registered except cmd_ready and busy.

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, FIFO empty, tri_start=0, clr_start=0, all argument outputs 0, jobs_done 0, busy 0.
REQ-027 Reset mid-job SHALL abandon the job and all queued commands; no start asserts until 2 cycles after rst_n deasserts.
REQ-028 cmd_ready SHALL be 0 while rst_n is low.

Structure
REQ-029 lab_pkg SHALL hold the FSM state enum, the job struct (x, y, diameter, colour, clear) and constants SCREEN_W=160, SCREEN_H=120.
REQ-030 The FIFO SHALL be a sub-module job_fifo (parameterised DEPTH, data type = job struct, full/empty/count outputs).
REQ-031 The implementation SHALL be 120-400 lines of RTL total.

Verification
REQ-032 Push (80,60,80,colour 5), engine done after 100 cycles -> tri_start high exactly until cycle after done, args stable, jobs_done=1.
REQ-033 Push 5 jobs with DEPTH=4 and engine stalled -> 4 accepted, cmd_ready=0 on 5th; drained in order, jobs_done=4.
REQ-034 Push clear job, then (0,119,30,3) -> clr_start only for first, tri_start only for second, gap of 2 low cycles between them.
REQ-035 Push (200,127,81,7) -> engine receives (159,119,80,7).
REQ-036 rst_n low during WAIT_DONE with 3 queued jobs -> starts drop immediately, busy=0, no launch after release until a new push.
REQ-037 Random 200-job stream against a behavioural engine with random done latency 0-50 -> scoreboard order/argument match, no overlapping starts, GAP respected.
